// File: rtl/tx_gearbox_66_64_pkg.sv
// Shared constants and types for the 40G PCS transmit lane gearboxes.
package pcs_tx_pkg;
    localparam int BLOCK_W           = 66;
    localparam int WORD_W            = 64;
    localparam int BLOCKS_PER_PERIOD = 32;
    localparam int NUM_LANES         = 4;

    // Residual bit count at which the gearbox must spend a cycle draining.
    localparam logic [6:0] R_FULL = 7'(2 * BLOCKS_PER_PERIOD);

    typedef logic [5:0] phase_t;
endpackage

// File: rtl/tx_gearbox_66_64_if.sv
// Block-in / word-out bundle for one transmit lane gearbox.
interface tx_gearbox_66_64_if;
    import pcs_tx_pkg::*;

    logic [BLOCK_W-1:0] in_block;
    logic               in_valid;
    logic               in_ready;
    logic [WORD_W-1:0]  out_word;
    logic               out_valid;
    phase_t             phase;

    modport master (output in_block, in_valid,
                    input  in_ready, out_word, out_valid, phase);
    modport slave  (input  in_block, in_valid,
                    output in_ready, out_word, out_valid, phase);
endinterface

// File: rtl/tx_gearbox_66_64_4lane.sv
// Four lane gearboxes on a common TX_CLK with a lockstep phase check.
module tx_gearbox_4lane
    import pcs_tx_pkg::*;
(
    input  logic                                TX_CLK,
    input  logic                                reset,
    input  logic [NUM_LANES-1:0][BLOCK_W-1:0]   in_block,
    input  logic [NUM_LANES-1:0]                in_valid,
    output logic [NUM_LANES-1:0]                in_ready,
    output logic [NUM_LANES-1:0][WORD_W-1:0]    out_word,
    output logic [NUM_LANES-1:0]                out_valid,
    output phase_t [NUM_LANES-1:0]              phase
);
    genvar g;
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
        tx_gearbox_66_64_if lane_if ();
        assign lane_if.in_block = in_block[g];
        assign lane_if.in_valid = in_valid[g];
        assign in_ready[g]      = lane_if.in_ready;
        assign out_word[g]      = lane_if.out_word;
        assign out_valid[g]     = lane_if.out_valid;
        assign phase[g]         = lane_if.phase;

        tx_gearbox_66_64 u_gb (
            .TX_CLK (TX_CLK),
            .reset  (reset),
            .gb     (lane_if.slave)
        );
    end

    // Lanes fed identical valid patterns since reset must share one phase.
    logic lock_q;
    always_ff @(posedge TX_CLK) begin
        if (!reset)
            lock_q <= 1'b1;
        else if (in_valid != {NUM_LANES{in_valid[0]}})
            lock_q <= 1'b0;
    end

    a_phase_lockstep: assert property (@(posedge TX_CLK) disable iff (!reset)
        lock_q |-> (phase == {NUM_LANES{phase[0]}}));
endmodule

// File: rtl/tx_gearbox_66_64.sv
// 66-bit block to 64-bit word transmit gearbox; stalls input one cycle in 33.
module tx_gearbox_66_64 #(
    parameter int BLOCK_W = pcs_tx_pkg::BLOCK_W,
    parameter int WORD_W  = pcs_tx_pkg::WORD_W
) (
    input  logic                 TX_CLK,
    input  logic                 reset,
    tx_gearbox_66_64_if.slave    gb
);
    import pcs_tx_pkg::*;

    // Residual never exceeds one word, so a single word register holds it;
    // bits at or above r_q are kept zero so the OR-merge below is clean.
    logic [6:0]          r_q, r_d;
    logic [WORD_W-1:0]   buf_q, buf_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic                vld_q, vld_d;
    logic [2*WORD_W-1:0] cat;
    logic                pause, accept;

    assign pause       = (r_q == R_FULL);
    assign gb.in_ready = reset && !pause;
    assign accept      = gb.in_ready && gb.in_valid;

    assign cat = ({{(2*WORD_W-BLOCK_W){1'b0}}, gb.in_block} << r_q)
               | {{WORD_W{1'b0}}, buf_q};

    always_comb begin
        r_d    = r_q;
        buf_d  = buf_q;
        word_d = word_q;
        vld_d  = 1'b0;
        if (pause) begin
            word_d = buf_q;
            vld_d  = 1'b1;
            buf_d  = '0;
            r_d    = '0;
        end else if (accept) begin
            word_d = cat[WORD_W-1:0];
            buf_d  = cat[2*WORD_W-1:WORD_W];
            vld_d  = 1'b1;
            r_d    = r_q + 7'd2;
        end
    end

    always_ff @(posedge TX_CLK) begin
        if (!reset) begin
            r_q    <= '0;
            buf_q  <= '0;
            word_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            r_q    <= r_d;
            buf_q  <= buf_d;
            word_q <= word_d;
            vld_q  <= vld_d;
        end
    end

    assign gb.out_word  = word_q;
    assign gb.out_valid = vld_q;
    assign gb.phase     = r_q[6:1];
endmodule

// File: tb/tb_tx_gearbox_66_64.sv
// Directed bench for the 66/64 gearbox: bit-queue scoreboard plus timed checks.
module tb_tx_gearbox_66_64;
    logic TX_CLK = 1'b0;
    logic reset  = 1'b0;

    always #5 TX_CLK = ~TX_CLK;

    tx_gearbox_66_64_if gb_if ();

    tx_gearbox_66_64 dut (
        .TX_CLK (TX_CLK),
        .reset  (reset),
        .gb     (gb_if)
    );

    logic [3:0][65:0] w_block;
    logic [3:0]       w_valid_in, w_ready, w_valid;
    logic [3:0][63:0] w_word;
    logic [3:0][5:0]  w_phase;
    assign w_block    = {4{gb_if.in_block}};
    assign w_valid_in = {4{gb_if.in_valid}};

    tx_gearbox_4lane u_4l (
        .TX_CLK    (TX_CLK),
        .reset     (reset),
        .in_block  (w_block),
        .in_valid  (w_valid_in),
        .in_ready  (w_ready),
        .out_word  (w_word),
        .out_valid (w_valid),
        .phase     (w_phase)
    );

    int checks = 0;
    int errors = 0;
    bit bitq[$];
    logic [63:0] last_exp = '0;

    localparam logic [65:0] ONES = 66'h3_FFFF_FFFF_FFFF_FFFF;

    task automatic chk(input string nm, input logic [65:0] act, input logic [65:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Offer one block for the coming edge; log its bits if it will be taken.
    task automatic step(input logic v, input logic [65:0] b, output logic acc);
        gb_if.in_valid = v;
        gb_if.in_block = b;
        acc = gb_if.in_ready & v;
        if (acc) for (int i = 0; i < 66; i++) bitq.push_back(b[i]);
        @(posedge TX_CLK); #1;
    endtask

    // Monitor: every valid word must be the next 64 bits of the accepted stream.
    always @(negedge TX_CLK) begin
        if (gb_if.out_valid) begin
            if (bitq.size() < 64) begin
                checks++;
                errors++;
                $display("FAIL word_underrun got=%h have_bits=%0d want=64", gb_if.out_word, bitq.size());
            end else begin
                logic [63:0] w;
                for (int i = 0; i < 64; i++) w[i] = bitq.pop_front();
                last_exp = w;
                chk("stream_word", {2'b0, gb_if.out_word}, {2'b0, w});
            end
        end
        if (reset) begin
            for (int l = 1; l < 4; l++) chk("lane_phase", {60'b0, w_phase[l]}, {60'b0, w_phase[0]});
            chk("lane0_vs_dut_phase", {60'b0, w_phase[0]}, {60'b0, gb_if.phase});
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic acc;
        logic [65:0] items[$];
        logic [65:0] blk;
        int idx, taken, cyc;

        gb_if.in_valid = 1'b0;
        gb_if.in_block = '0;
        reset = 1'b0;
        repeat (3) begin @(posedge TX_CLK); #1; end
        chk("rst_out_valid", gb_if.out_valid, 0);
        chk("rst_out_word",  gb_if.out_word, 0);
        chk("rst_phase",     gb_if.phase, 0);
        chk("rst_in_ready",  gb_if.in_ready, 0);

        items.push_back(66'h2_0000_0000_0000_0001);
        for (int k = 0; k < 64; k++) items.push_back({2'b01, 64'(k)});

        reset = 1'b1;
        #1;
        idx = 0;
        for (int c = 0; c < 68; c++) begin
            chk("in_ready_sched", gb_if.in_ready, (c != 32 && c != 65));
            blk = (c == 32 || c == 33) ? ONES : items[idx];
            if (c == 33) chk("retry_at_phase0", gb_if.phase, 0);
            step(1'b1, blk, acc);
            if (c == 32) chk("pause_block_ignored", acc, 0);
            else if (c != 33 && acc) idx++;
            if (c == 0) begin
                chk("first_word",  gb_if.out_word, 64'h1);
                chk("first_valid", gb_if.out_valid, 1);
                chk("first_phase", gb_if.phase, 1);
            end
            if (c == 1) chk("residual_10_word", gb_if.out_word, 64'h2);
        end
        chk("items_consumed", idx, 65);
        chk("phase_after_feed", gb_if.phase, 2);

        for (int k = 0; k < 8; k++) step(1'b1, {2'b10, 64'h100 + 64'(k)}, acc);
        chk("phase_before_gap", gb_if.phase, 10);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, ONES, acc);
            chk("gap_out_valid", gb_if.out_valid, 0);
            chk("gap_phase", gb_if.phase, 10);
            chk("gap_word_hold", gb_if.out_word, last_exp);
        end
        for (int k = 0; k < 7; k++) step(1'b1, {2'b01, 64'hC0DE_0000_0000_0000 + 64'(k)}, acc);
        chk("phase_before_reset", gb_if.phase, 17);

        reset = 1'b0;
        @(negedge TX_CLK); #1;
        bitq.delete();
        step(1'b1, 66'h2_AAAA_5555_AAAA_5555, acc);
        chk("reset_no_accept",   acc, 0);
        chk("mid_rst_out_valid", gb_if.out_valid, 0);
        chk("mid_rst_out_word",  gb_if.out_word, 0);
        chk("mid_rst_phase",     gb_if.phase, 0);
        chk("mid_rst_in_ready",  gb_if.in_ready, 0);

        reset = 1'b1;
        #1;
        step(1'b1, 66'h1_2345_6789_ABCD_EF01, acc);
        chk("post_rst_word",  gb_if.out_word, 64'h2345_6789_ABCD_EF01);
        chk("post_rst_valid", gb_if.out_valid, 1);
        chk("post_rst_phase", gb_if.phase, 1);

        taken = 0;
        cyc = 0;
        while (taken < 140 && cyc < 200) begin
            step(1'b1, {(taken % 2 == 0) ? 2'b10 : 2'b01,
                        64'hDEAD_0000_0000_0000 + 64'(taken) * 64'h1_0001}, acc);
            if (acc) taken++;
            cyc++;
            chk("steady_out_valid", gb_if.out_valid, 1);
        end
        chk("steady_accepts", taken, 140);

        step(1'b0, '0, acc);
        step(1'b0, '0, acc);
        @(negedge TX_CLK); #1;
        chk("residual_bits_left", bitq.size(), 26);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
